ahb_arbiter: RTL
================

// Module: ahb_arbiter
// PURPOSE
//   Two-master AHB-Lite bus arbiter sitting directly upstream of master_to_slave_mult.
//   Takes bus requests and lock requests from master 1 and master 2, issues HGRANTx,
//   and produces the registered HMASTER / HMASTLOCK that steer the master-to-slave mux.
//   Keeps fixed-length bursts and locked sequences on one master.
//   Parks the bus on a default master when nobody requests.
// PARAMETERS
//   DEFAULT_MASTER  1   master parked on when no requests pending (1 or 2)
//   INCR_HOLD_BEATS 4   max beats an undefined-length INCR burst keeps its grant before re-arbitration
//   CNT_W           4   width of the internal beat counter; must satisfy 2**CNT_W >= 16
// PORTS
//   HCLK       in   1  bus clock, rising edge
//   HRESETn    in   1  asynchronous active-low reset
//   HREADY     in   1  transfer-complete from selected slave
//   HBUSREQ1   in   1  bus request, master 1
//   HBUSREQ2   in   1  bus request, master 2
//   HLOCK1     in   1  lock request, master 1
//   HLOCK2     in   1  lock request, master 2
//   HTRANS     in   2  muxed HTRANS (IDLE=00 BUSY=01 NONSEQ=10 SEQ=11)
//   HBURST     in   3  muxed HBURST (SINGLE=0 INCR=1 WRAP4=2 INCR4=3 WRAP8=4 INCR8=5 WRAP16=6 INCR16=7)
//   HGRANT1    out  1  grant to master 1
//   HGRANT2    out  1  grant to master 2
//   HMASTER    out  2  owner of current address phase: 01=master1, 10=master2, 00 never driven after reset
//   HMASTLOCK  out  1  current address phase is part of a locked sequence
// BEHAVIOUR
//   Reset (async, HRESETn=0): grant = DEFAULT_MASTER, HMASTER = its encoding,
//     HMASTLOCK=0, beat counter=0, FSM=ARB. Outputs hold their reset values until the first HCLK edge after release.
//   FSM states: ARB, BURST, LOCKED. All transitions happen only on an HCLK edge with HREADY=1.
//     HREADY=0 freezes grants, the counter and the FSM state.
//   ARB: re-arbitrate each HREADY cycle.
//     Fixed priority: master 1 over master 2.
//     No request: park on DEFAULT_MASTER.
//     Transition on an owner NONSEQ:
//       - HBURST in {4/8/16-beat types}: load counter = beats-1, go to BURST.
//       - HBURST=INCR: load counter = INCR_HOLD_BEATS-1, go to BURST.
//       - Owner's HLOCK=1: go to LOCKED (takes precedence over BURST).
//   BURST: grant held.
//     - Counter decrements on each SEQ with HREADY=1.
//     - BUSY does not decrement the counter.
//     - Counter reaching 0: FSM returns to ARB. Re-arbitration then takes effect on the same edge, so the grant moves for the next address phase.
//     - IDLE, or NONSEQ, during BURST (early termination): clear counter, go to ARB.
//   LOCKED: grant held while owner HLOCK=1.
//     - Owner drops HLOCK: go to ARB after the following HREADY=1 edge, so the final locked data phase completes.
//   HGRANTx: registered, exactly one-hot at all times.
//   HMASTER / HMASTLOCK:
//     - Registered on HREADY=1 edges from the grant/lock state of the previous cycle.
//     - Latency: HGRANT change -> HMASTER change = 1 HREADY=1 cycle.
//   Simultaneous HBUSREQ1 & HBUSREQ2 in ARB: priority rule decides.
//   Requester deasserting HBUSREQ while granted in ARB: grant moves at the next HREADY=1 edge.
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN defined:
//     - Round-robin arbitration: the master granted last has lowest priority at each ARB decision.
//     - Parking is unchanged.
//   ARB_ROUND_ROBIN_EN undefined: fixed priority, master 1 highest.
// STRUCTURE
//   Package ahb_pkg:
//     - HTRANS/HBURST encoding constants.
//     - HMASTER codes (HM_M1=2'b01, HM_M2=2'b10).
//     - Arbiter state enum.
//     - Function burst_beats(HBURST) returning the beat count.
//   Sub-module ahb_beat_counter:
//     - Ports: load, load value, decrement on SEQ & HREADY, clear, zero flag.
//   Top-level contents: FSM, priority/round-robin logic, output registers.
// TESTING
//   1. Reset: hold HRESETn=0, no requests -> HGRANT1=1, HGRANT2=0, HMASTER=01, HMASTLOCK=0;
//      release, no requests -> same values persist.
//   2. Priority: HBUSREQ1=HBUSREQ2=1, HREADY=1 -> HGRANT1=1 every cycle, HMASTER=01;
//      drop HBUSREQ1 -> HGRANT2=1 next edge, HMASTER=10 one edge later.
//   3. INCR4 burst by master 2 (NONSEQ + 3 SEQ, HREADY=1), HBUSREQ1 raised on beat 1
//      -> HGRANT2 held until the third SEQ; HGRANT1=1 on that edge; HMASTER=01 next edge.
//   4. Wait states: same INCR4 with HREADY=0 for 2 cycles mid-burst
//      -> grant, counter and HMASTER frozen; burst still spans exactly 4 beats.
//   5. Lock: master 1 HLOCK1=1 over 3 SINGLE transfers, HBUSREQ2=1 throughout
//      -> HMASTLOCK=1 for those phases; HGRANT2 asserted only after HLOCK1 drops plus 1 HREADY cycle.
//   6. Mid-burst reset: HRESETn=0 during an INCR8 -> outputs at reset values immediately (asynchronous);
//      after release FSM=ARB, counter=0.
//      With ARB_ROUND_ROBIN_EN: both requesting with SINGLE transfers -> grants alternate 1,2,1,2.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, HMASTER codes, arbiter state type and burst
// length decode used by the arbiter and its beat counter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    // HMASTER codes double as the one-hot grant vector ({HGRANT2, HGRANT1}).
    localparam logic [1:0] HM_M1 = 2'b01;
    localparam logic [1:0] HM_M2 = 2'b10;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_BURST  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    // Beat count of a burst type; INCR has no defined length and returns 0.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        logic [4:0] beats;
        case (hburst)
            HBURST_SINGLE:               beats = 5'd1;
            HBURST_WRAP4,  HBURST_INCR4: beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8: beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
            default:                     beats = 5'd0;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// Remaining-beat counter for a held burst: load on burst start, count down
// on each completed SEQ beat, clear on early termination.
module ahb_beat_counter
#(
    parameter int CNT_W = 4
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Clear beats load, load beats decrement; never wraps below zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB-Lite arbiter: fixed-priority (master 1 first) or, with
// ARB_ROUND_ROBIN_EN defined, round-robin arbitration. Holds the grant for
// fixed-length/INCR bursts and locked sequences, parks on DEFAULT_MASTER,
// and registers HMASTER/HMASTLOCK one HREADY cycle behind the grant.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int DEFAULT_MASTER  = 1,
    parameter int INCR_HOLD_BEATS = 4,
    parameter int CNT_W           = 4
)
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADY,
    input  logic       HBUSREQ1,
    input  logic       HBUSREQ2,
    input  logic       HLOCK1,
    input  logic       HLOCK2,
    input  logic [1:0] HTRANS,
    input  logic [2:0] HBURST,
    output logic       HGRANT1,
    output logic       HGRANT2,
    output logic [1:0] HMASTER,
    output logic       HMASTLOCK
);

    localparam logic [1:0] S_ARB     = ST_ARB;
    localparam logic [1:0] S_BURST   = ST_BURST;
    localparam logic [1:0] S_LOCKED  = ST_LOCKED;
    localparam logic [1:0] DEF_GRANT = (DEFAULT_MASTER == 2) ? HM_M2 : HM_M1;

    logic [1:0]       r_state;
    logic [1:0]       r_grant;
    logic [1:0]       r_hmaster;
    logic             r_hmastlock;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_grant_nxt;
    logic [1:0]       w_arb_grant;
    logic             w_gnt_lock;
    logic             w_owner_granted;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_clear;
    logic             w_dec;
    logic [CNT_W-1:0] w_count;
    logic             w_zero;
    logic             w_cnt_last;
    logic [4:0]       w_beats;

    assign w_gnt_lock      = r_grant[0] ? HLOCK1 : HLOCK2;
    // A NONSEQ only starts a burst/lock if its issuer still holds the grant.
    assign w_owner_granted = (r_grant == r_hmaster);
    assign w_beats         = burst_beats(HBURST);
    assign w_cnt_last      = w_zero || (w_count == CNT_W'(1));
    assign w_dec           = HREADY && (r_state == S_BURST) && (HTRANS == HTRANS_SEQ);

    // Arbitration decision: who would own the bus if the grant were free now.
    always_comb begin
        w_arb_grant = DEF_GRANT;
`ifdef ARB_ROUND_ROBIN_EN
        if (HBUSREQ1 && HBUSREQ2) begin
            w_arb_grant = r_grant[0] ? HM_M2 : HM_M1;
        end else if (HBUSREQ1) begin
            w_arb_grant = HM_M1;
        end else if (HBUSREQ2) begin
            w_arb_grant = HM_M2;
        end
`else
        if (HBUSREQ1) begin
            w_arb_grant = HM_M1;
        end else if (HBUSREQ2) begin
            w_arb_grant = HM_M2;
        end
`endif
    end

    // FSM next state, next grant and beat-counter control.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_clear     = 1'b0;
        case (r_state)
            S_ARB: begin
                w_grant_nxt = w_arb_grant;
                if ((HTRANS == HTRANS_NONSEQ) && w_owner_granted) begin
                    if (w_gnt_lock) begin
                        w_state_nxt = S_LOCKED;
                        w_grant_nxt = r_grant;
                    end else if (HBURST == HBURST_INCR) begin
                        w_state_nxt = S_BURST;
                        w_grant_nxt = r_grant;
                        w_load      = 1'b1;
                        w_load_val  = CNT_W'(INCR_HOLD_BEATS - 1);
                    end else if (HBURST != HBURST_SINGLE) begin
                        w_state_nxt = S_BURST;
                        w_grant_nxt = r_grant;
                        w_load      = 1'b1;
                        w_load_val  = CNT_W'(w_beats - 5'd1);
                    end
                end
            end
            S_BURST: begin
                if ((HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ)) begin
                    w_state_nxt = S_ARB;
                    w_clear     = 1'b1;
                end else if ((HTRANS == HTRANS_SEQ) && w_cnt_last) begin
                    // Last beat: re-arbitrate on this same edge.
                    w_state_nxt = S_ARB;
                    w_grant_nxt = w_arb_grant;
                end
            end
            S_LOCKED: begin
                // Grant stays one more HREADY cycle so the last locked data phase completes.
                if (!w_gnt_lock) begin
                    w_state_nxt = S_ARB;
                end
            end
            default: begin
                w_state_nxt = S_ARB;
            end
        endcase
    end

    // State, grant and address-phase owner registers; all frozen while HREADY=0.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_ARB;
            r_grant     <= DEF_GRANT;
            r_hmaster   <= DEF_GRANT;
            r_hmastlock <= 1'b0;
        end else if (HREADY) begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_hmaster   <= r_grant;
            r_hmastlock <= w_gnt_lock;
        end
    end

    ahb_beat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk      (HCLK),
        .i_rst_n    (HRESETn),
        .i_load     (HREADY && w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .i_clear    (HREADY && w_clear),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    assign HGRANT1   = r_grant[0];
    assign HGRANT2   = r_grant[1];
    assign HMASTER   = r_hmaster;
    assign HMASTLOCK = r_hmastlock;

endmodule
